led_panel_client: RTL and testbench

- Display-side counterpart of the LED panel server. The server sequences rows, columns and bitplanes and broadcasts `memAddrMst`/`bitplaneMst`; this block turns that broadcast into the six RGB data lines of one HUB75 panel.
- It holds a double-buffered framebuffer (front/back, upper/lower half) that the host writes over a simple write port.
- Buffers swap only at the server's `v_sync` frame boundary, so a displayed frame never tears.

---
 rtl/led_panel_pkg.sv | 25 ++
 rtl/led_panel_dpram.sv | 29 ++
 rtl/led_panel_client.sv | 148 ++++++++++++++
 tb/tb_led_panel_client.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_panel_pkg.sv
// Shared types and constants for the LED panel client: FSM encoding, pixel layout
// and the bitplane extraction helper used on the display read path.
package led_panel_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int PIX_W              = 24;
    localparam int R_LSB              = 16;
    localparam int G_LSB              = 8;
    localparam int B_LSB              = 0;
    localparam int DEFAULT_COLOR_BITS = 8;
    localparam int BP_W               = 3;

    // Returns {R, G, B} bits of bitplane bp; each channel's LSB sits at its field offset.
    function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0] pix,
                                              input logic [BP_W-1:0]  bp);
        logic [PIX_W-1:0] sh;
        sh = pix >> bp;
        return {sh[R_LSB], sh[G_LSB], sh[B_LSB]};
    endfunction

endpackage

// File: rtl/led_panel_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address read in the write cycle returns the old word.
module led_panel_dpram
    import led_panel_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = PIX_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/led_panel_client.sv
// LED panel client: turns the server's {row,col}/bitplane broadcast into HUB75 RGB lines
// from a double-buffered framebuffer the host fills over a simple write port.
module led_panel_client
    import led_panel_pkg::*;
#(
    parameter int  COLOR_BITS         = DEFAULT_COLOR_BITS,
    parameter int  DISPLAY_ROWS_LINES = 4,
    parameter int  DISPLAY_COLS_LINES = 6,
    localparam int A                  = DISPLAY_ROWS_LINES + DISPLAY_COLS_LINES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [A-1:0]     memAddrMst,
    input  logic [BP_W-1:0]  bitplaneMst,
    input  logic             v_sync,
    input  logic [A:0]       memAddrIn,
    input  logic [PIX_W-1:0] memDataIn,
    input  logic             memWrite,
    input  logic             swapReq,
    output logic             swapAck,
    output logic             ready,
    output logic             R0,
    output logic             G0,
    output logic             B0,
    output logic             R1,
    output logic             G1,
    output logic             B1,
    output state_e           dbg_state
);

    state_e            state_q, state_d;
    logic [A-1:0]      clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;
    logic              front_sel_q, front_sel_d;
    logic              swap_pending_q, swap_pending_d;
    logic              swap_ack_q, swap_ack_d;
    logic              vsync_q, swap_req_q;
    logic [A-1:0]      rd_addr_q;
    logic [BP_W-1:0]   bp_q, bp_rd_q;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_valid_q, rd_valid_d;
    logic [5:0]        rgb_q, rgb_d;

    logic              vsync_rise, swap_req_rise, swap_now, plane_ok, init_wr;
    logic [A-1:0]      wr_addr;
    logic [PIX_W-1:0]  wr_data, pix_hi, pix_lo;
    logic [PIX_W-1:0]  rdata [2][2];

    // Swap handshake: a swapReq rising edge arms a pending swap; the next v_sync rising
    // edge toggles the front buffer and pulses swapAck once. The host holds off writes
    // from swapReq until swapAck.
    always_comb begin
        vsync_rise     = v_sync & ~vsync_q;
        swap_req_rise  = swapReq & ~swap_req_q;
        swap_now       = vsync_rise & (swap_pending_q | swap_req_rise);
        front_sel_d    = front_sel_q ^ swap_now;
        swap_pending_d = swap_now ? 1'b0 : (swap_pending_q | swap_req_rise);
        swap_ack_d     = swap_now;

        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        init_wr   = (state_q == S_INIT);
        if (init_wr) begin
            clr_cnt_d = clr_cnt_q + {{(A-1){1'b0}}, 1'b1};
            if (&clr_cnt_q) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        end

        wr_addr = init_wr ? clr_cnt_q : memAddrIn[A-1:0];
        wr_data = init_wr ? '0 : memDataIn;

        // Bank choice is captured with the RAM read so the output mux matches the read.
        rd_sel_d   = front_sel_q;
        rd_valid_d = (state_q == S_RUN);

        pix_hi   = rd_sel_q ? rdata[1][0] : rdata[0][0];
        pix_lo   = rd_sel_q ? rdata[1][1] : rdata[0][1];
        plane_ok = (int'(bp_rd_q) < COLOR_BITS);
        rgb_d    = '0;
        if (rd_valid_q && plane_ok) begin
            rgb_d = {plane_bits(pix_hi, bp_rd_q), plane_bits(pix_lo, bp_rd_q)};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= S_INIT;
            clr_cnt_q      <= '0;
            ready_q        <= 1'b0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_ack_q     <= 1'b0;
            vsync_q        <= 1'b0;
            swap_req_q     <= 1'b0;
            rd_addr_q      <= '0;
            bp_q           <= '0;
            bp_rd_q        <= '0;
            rd_sel_q       <= 1'b0;
            rd_valid_q     <= 1'b0;
            rgb_q          <= '0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            ready_q        <= ready_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            swap_ack_q     <= swap_ack_d;
            vsync_q        <= v_sync;
            swap_req_q     <= swapReq;
            rd_addr_q      <= memAddrMst;
            bp_q           <= bitplaneMst;
            bp_rd_q        <= bp_q;
            rd_sel_q       <= rd_sel_d;
            rd_valid_q     <= rd_valid_d;
            rgb_q          <= rgb_d;
        end
    end

    // Four arrays: bank b (front/back) x half h (upper/lower). Init clears all in parallel.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar h = 0; h < 2; h++) begin : g_half
            logic we;
            assign we = init_wr |
                        (memWrite & (front_sel_q != 1'(b)) & (memAddrIn[A] == 1'(h)));

            led_panel_dpram #(
                .AW (A),
                .DW (PIX_W)
            ) u_ram (
                .clk   (CLK),
                .we    (we),
                .waddr (wr_addr),
                .wdata (wr_data),
                .raddr (rd_addr_q),
                .rdata (rdata[b][h])
            );
        end
    end

    assign {R0, G0, B0, R1, G1, B1} = rgb_q;
    assign swapAck   = swap_ack_q;
    assign ready     = ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_led_panel_client.sv
// Bench for led_panel_client: randomized and directed stimulus, a framebuffer reference
// model feeding an expected queue, and a per-cycle monitor that pops and compares.
module tb_led_panel_client;
    import led_panel_pkg::*;

    localparam int A = 10;
    localparam int D = 1 << A;

    logic             CLK = 1'b0;
    logic             RST;
    logic [A-1:0]     memAddrMst;
    logic [2:0]       bitplaneMst;
    logic             v_sync;
    logic [A:0]       memAddrIn;
    logic [23:0]      memDataIn;
    logic             memWrite;
    logic             swapReq;
    logic             swapAck, ready;
    logic             R0, G0, B0, R1, G1, B1;
    state_e           dbg_state;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               ack_cnt  = 0;
    logic [7:0]       exp_q[$];

    always #5 CLK = ~CLK;

    led_panel_client dut (
        .CLK         (CLK),
        .RST         (RST),
        .memAddrMst  (memAddrMst),
        .bitplaneMst (bitplaneMst),
        .v_sync      (v_sync),
        .memAddrIn   (memAddrIn),
        .memDataIn   (memDataIn),
        .memWrite    (memWrite),
        .swapReq     (swapReq),
        .swapAck     (swapAck),
        .ready       (ready),
        .R0          (R0),
        .G0          (G0),
        .B0          (B0),
        .R1          (R1),
        .G1          (G1),
        .B1          (B1),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: framebuffer[bank][half][addr], front bank, pending swap, and the
    // pixel fetched at the previous edge that reaches the pins one edge later.
    logic [23:0] fb [2][2][D];
    logic        m_front, m_pending, m_ready, m_prev_vs, m_prev_req, m_ack;
    logic        m_vs_rise, m_rq_rise;
    int          m_clr;
    logic [23:0] m_pix_u, m_pix_l;
    logic [2:0]  m_pix_bp, m_req_bp;
    logic [A-1:0] m_req_addr;
    logic [5:0]  m_rgb;

    function automatic logic [2:0] planes(input logic [23:0] p, input logic [2:0] b);
        logic [23:0] s;
        s = p >> b;
        return {s[16], s[8], s[0]};
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            for (int b = 0; b < 2; b++)
                for (int h = 0; h < 2; h++)
                    for (int i = 0; i < D; i++)
                        fb[b][h][i] = 24'h0;
            m_front = 0; m_pending = 0; m_ready = 0; m_clr = 0;
            m_prev_vs = 0; m_prev_req = 0;
            m_pix_u = 0; m_pix_l = 0; m_pix_bp = 0; m_req_addr = 0; m_req_bp = 0;
            exp_q.push_back(8'h00);
        end else begin
            m_ack = 0;
            m_rgb = {planes(m_pix_u, m_pix_bp), planes(m_pix_l, m_pix_bp)};
            m_pix_u  = fb[m_front][0][m_req_addr];
            m_pix_l  = fb[m_front][1][m_req_addr];
            m_pix_bp = m_req_bp;
            m_req_addr = memAddrMst;
            m_req_bp   = bitplaneMst;
            if (m_ready && memWrite)
                fb[!m_front][memAddrIn[A]][memAddrIn[A-1:0]] = memDataIn;
            m_vs_rise  = v_sync && !m_prev_vs;
            m_rq_rise  = swapReq && !m_prev_req;
            m_prev_vs  = v_sync;
            m_prev_req = swapReq;
            if (m_rq_rise) m_pending = 1;
            if (m_vs_rise && m_pending) begin
                m_front   = !m_front;
                m_pending = 0;
                m_ack     = 1;
            end
            if (!m_ready) begin
                m_clr++;
                if (m_clr == D) m_ready = 1;
            end
            exp_q.push_back({m_ready, m_ack, m_rgb});
        end
    end

    // Monitor: outputs are presented every cycle, so one expected entry is consumed per cycle.
    always @(negedge CLK) begin
        logic [7:0] exp_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            if (RST) exp_v = 8'h00;
            check("outputs", 32'({ready, swapAck, R0, G0, B0, R1, G1, B1}), 32'(exp_v));
        end
        if (swapAck) ack_cnt++;
    end

    task automatic read_sample(input logic [A-1:0] addr, input logic [2:0] bp,
                               output logic [5:0] v);
        @(negedge CLK);
        memAddrMst  = addr;
        bitplaneMst = bp;
        repeat (3) @(negedge CLK);
        v = {R0, G0, B0, R1, G1, B1};
    endtask

    task automatic vsync_pulse();
        @(negedge CLK); v_sync = 1'b1;
        repeat (4) @(negedge CLK);
        v_sync = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic host_write(input logic half, input logic [A-1:0] addr, input logic [23:0] data);
        @(negedge CLK);
        memWrite = 1'b1; memAddrIn = {half, addr}; memDataIn = data;
        @(negedge CLK);
        memWrite = 1'b0;
    endtask

    task automatic do_swap(input string name);
        int base;
        base = ack_cnt;
        @(negedge CLK); swapReq = 1'b1;
        vsync_pulse();
        @(negedge CLK); swapReq = 1'b0;
        check(name, 32'(ack_cnt - base), 32'd1);
    endtask

    task automatic check_addr_zero(input logic [A-1:0] addr, input string name);
        logic [5:0] v, acc;
        acc = '0;
        for (int bp = 0; bp < 8; bp++) begin
            read_sample(addr, 3'(bp), v);
            acc = acc | v;
        end
        check(name, 32'(acc), 32'd0);
    endtask

    task automatic run_init_check();
        int first_ready;
        first_ready = 0;
        for (int i = 1; i <= D + 4; i++) begin
            @(negedge CLK);
            if (ready && first_ready == 0) first_ready = i;
            memAddrMst  = A'($urandom_range(0, D - 1));
            bitplaneMst = 3'($urandom_range(0, 7));
            memWrite    = (i < D - 2);
            memAddrIn   = {1'($urandom_range(0, 1)), A'(7)};
            memDataIn   = 24'($urandom) | 24'h1;
        end
        memWrite = 1'b0;
        check("ready_latency", 32'(first_ready), 32'(D));
        check("state_run", 32'(dbg_state), 32'(S_RUN));
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [5:0] v;
        logic [7:0] r_seq, g_seq, b_seq;
        int base;

        RST = 1'b1; memAddrMst = '0; bitplaneMst = '0; v_sync = 1'b0;
        memAddrIn = '0; memDataIn = '0; memWrite = 1'b0; swapReq = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_state", 32'(dbg_state), 32'(S_INIT));
        check("reset_ready", 32'(ready), 32'd0);
        @(negedge CLK); RST = 1'b0;

        // Clear sweep with writes that must be dropped, then both buffers read back zero.
        run_init_check();
        check_addr_zero(A'(7), "init_write_dropped_front");
        check_addr_zero(A'($urandom_range(0, D - 1)), "cleared_front");
        do_swap("swap_ack_init");
        check_addr_zero(A'(7), "init_write_dropped_back");

        // Upper pixel 0xA53C81 through a swap, swept across all bitplanes.
        host_write(1'b0, A'(5), 24'hA5_3C_81);
        do_swap("swap_ack_upper");
        r_seq = '0; g_seq = '0; b_seq = '0;
        for (int bp = 0; bp < 8; bp++) begin
            read_sample(A'(5), 3'(bp), v);
            r_seq = {v[5], r_seq[7:1]};
            g_seq = {v[4], g_seq[7:1]};
            b_seq = {v[3], b_seq[7:1]};
        end
        check("r0_planes", 32'(r_seq), 32'h A5);
        check("g0_planes", 32'(g_seq), 32'h 3C);
        check("b0_planes", 32'(b_seq), 32'h 81);

        // Lower write stays invisible until swapped in.
        host_write(1'b1, A'(0), 24'hFF_FF_FF);
        read_sample(A'(0), 3'($urandom_range(0, 7)), v);
        check("lower_before_swap", 32'(v[2:0]), 32'd0);
        do_swap("swap_ack_lower");
        read_sample(A'(0), 3'($urandom_range(0, 7)), v);
        check("lower_after_swap", 32'(v[2:0]), 32'd7);

        // v_sync without a request changes nothing.
        base = ack_cnt;
        vsync_pulse();
        vsync_pulse();
        check("no_req_no_ack", 32'(ack_cnt - base), 32'd0);
        read_sample(A'(0), 3'($urandom_range(0, 7)), v);
        check("front_unchanged", 32'(v[2:0]), 32'd7);

        // Request rising together with the v_sync edge swaps exactly once.
        base = ack_cnt;
        @(negedge CLK); swapReq = 1'b1; v_sync = 1'b1;
        repeat (4) @(negedge CLK);
        v_sync = 1'b0;
        repeat (2) @(negedge CLK);
        swapReq = 1'b0;
        check("coincident_swap", 32'(ack_cnt - base), 32'd1);
        read_sample(A'(0), 3'($urandom_range(0, 7)), v);
        check("coincident_front", 32'(v[2:0]), 32'd0);

        // Random traffic on a small address window so reads hit written pixels.
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            memAddrMst  = A'($urandom_range(0, 15));
            bitplaneMst = 3'($urandom_range(0, 7));
            memWrite    = ($urandom_range(0, 1) == 1);
            memAddrIn   = {1'($urandom_range(0, 1)), A'($urandom_range(0, 15))};
            memDataIn   = 24'($urandom);
            if (c % 40 == 0) v_sync = 1'b1;
            if (c % 40 == 4) v_sync = 1'b0;
            if ($urandom_range(0, 29) == 0) swapReq = !swapReq;
        end
        @(negedge CLK);
        memWrite = 1'b0; swapReq = 1'b0; v_sync = 1'b0;
        host_write(1'b0, A'(3), 24'hFF_FF_FF);
        do_swap("swap_ack_pre_reset");
        @(negedge CLK); memAddrMst = A'(3); bitplaneMst = 3'd2;
        repeat (4) @(negedge CLK);

        // Asynchronous reset mid-frame, then a full re-clear.
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("async_reset_outputs", 32'({R0, G0, B0, R1, G1, B1}), 32'd0);
        check("async_reset_ready", 32'(ready), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        run_init_check();
        check_addr_zero(A'(3), "recleared_front");
        do_swap("swap_ack_post_reset");
        check_addr_zero(A'(3), "recleared_back");
        check_addr_zero(A'(7), "recleared_init_write");

        repeat (4) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
